memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/chipset_pkg.sv | 14 +
 rtl/arbiter_starve_counter.sv | 31 +++
 rtl/memory_arbiter.sv | 133 +++++++++++++
 tb/tb_memory_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chipset_pkg.sv
// Shared chipset types: arbiter state encoding and RAM geometry.
// Imported by memory_arbiter and its sub-modules.
package chipset_pkg;

  localparam int RAM_ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CPU_ACCESS   = 2'd1,
    CPU_HOLD     = 2'd2,
    VIDEO_ACCESS = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arbiter_starve_counter.sv
// Counts video grants made while the CPU waits; flags when the CPU must win.
// Ports: clock, reset_n, cpu_req, cpu_grant, video_grant in; at_limit out.
module arbiter_starve_counter #(
  parameter int LIMIT = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic cpu_req,
  input  logic cpu_grant,
  input  logic video_grant,
  output logic at_limit
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] starve_cnt;

  assign at_limit = (starve_cnt == LIM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!cpu_req || cpu_grant) begin
      starve_cnt <= '0;
    end else if (video_grant && !at_limit) begin
      starve_cnt <= starve_cnt + W'(1);
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM between the CPU and the video fetcher, one access per grant.
// Ports: cpu_* (req/we/address/data, ready), video_* (req/address/data/ack),
// ram_* (ce/we/address/data). MEMORY_ARBITER_FAIR_EN adds CPU anti-starvation.
module memory_arbiter
  import chipset_pkg::*;
#(
  parameter int ADDR_W       = RAM_ADDR_W,
  parameter int RAM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [7:0]        cpu_data_in,
  output logic [7:0]        cpu_data_out,
  output logic              cpu_ready,
  input  logic              video_req,
  input  logic [ADDR_W-1:0] video_address,
  output logic [7:0]        video_data_out,
  output logic              video_ack,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_data_out,
  input  logic [7:0]        ram_data_in
);

  if (RAM_LATENCY < 1 || RAM_LATENCY > 3 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("memory_arbiter: illegal parameter value");
  end

  localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);

  arb_state_t state;
  arb_state_t state_next;
  logic [1:0] lat_cnt;
  logic       last;
  logic       cpu_win;
  logic       cpu_grant;
  logic       video_grant;

  assign last      = (lat_cnt == LAT_LAST);
  assign cpu_ready = ~(cpu_req & (state != CPU_HOLD));

`ifdef MEMORY_ARBITER_FAIR_EN
  logic at_limit;

  arbiter_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_grant  (cpu_grant),
    .video_grant(video_grant),
    .at_limit   (at_limit)
  );

  assign cpu_win = cpu_req & (~video_req | at_limit);
`else
  assign cpu_win = cpu_req & ~video_req;
`endif

  always_comb begin
    state_next  = state;
    cpu_grant   = 1'b0;
    video_grant = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_win) begin
          state_next = CPU_ACCESS;
          cpu_grant  = 1'b1;
        end else if (video_req) begin
          state_next  = VIDEO_ACCESS;
          video_grant = 1'b1;
        end
      end
      CPU_ACCESS: begin
        // A request dropped mid-access is already served.
        if (last) state_next = cpu_req ? CPU_HOLD : IDLE;
      end
      CPU_HOLD: begin
        if (!cpu_req) state_next = IDLE;
      end
      VIDEO_ACCESS: begin
        if (last) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // ram_ce is high exactly while in an access state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt        <= '0;
      ram_ce         <= 1'b0;
      ram_we         <= 1'b0;
      ram_address    <= '0;
      ram_data_out   <= '0;
      cpu_data_out   <= '0;
      video_data_out <= '0;
      video_ack      <= 1'b0;
    end else begin
      video_ack <= 1'b0;
      if (cpu_grant || video_grant) begin
        lat_cnt     <= '0;
        ram_ce      <= 1'b1;
        ram_we      <= cpu_grant & cpu_we;
        ram_address <= cpu_grant ? cpu_address : video_address;
        if (cpu_grant) ram_data_out <= cpu_data_in;
      end else if (ram_ce) begin
        lat_cnt <= lat_cnt + 2'd1;
        if (last) begin
          ram_ce <= 1'b0;
          ram_we <= 1'b0;
          if (state == VIDEO_ACCESS) begin
            video_data_out <= ram_data_in;
            video_ack      <= 1'b1;
          end else if (!ram_we) begin
            cpu_data_out <= ram_data_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: CPU vector table plus
// contention, mid-access drop and mid-access reset sequences.
module tb_memory_arbiter;
  import chipset_pkg::*;

  localparam int AW  = RAM_ADDR_W;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_address = '0;
  logic [7:0]    cpu_data_in = '0;
  logic [7:0]    cpu_data_out;
  logic          cpu_ready;
  logic          video_req = 1'b0;
  logic [AW-1:0] video_address = '0;
  logic [7:0]    video_data_out;
  logic          video_ack;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data_out;
  logic [7:0]    ram_data_in;

  memory_arbiter #(
    .ADDR_W      (AW),
    .RAM_LATENCY (LAT),
    .STARVE_LIMIT(3)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_address   (cpu_address),
    .cpu_data_in   (cpu_data_in),
    .cpu_data_out  (cpu_data_out),
    .cpu_ready     (cpu_ready),
    .video_req     (video_req),
    .video_address (video_address),
    .video_data_out(video_data_out),
    .video_ack     (video_ack),
    .ram_ce        (ram_ce),
    .ram_we        (ram_we),
    .ram_address   (ram_address),
    .ram_data_out  (ram_data_out),
    .ram_data_in   (ram_data_in)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:(1<<AW)-1];
  assign ram_data_in = mem[ram_address];

  always @(posedge clock) begin
    if (!reset_n) begin
      mem[17'h00100] <= 8'hA5;
      mem[17'h00200] <= 8'h77;
    end else if (ram_ce && ram_we) begin
      mem[ram_address] <= ram_data_out;
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
  } vec_t;

  vec_t vecs [6];

  int tests = 0;
  int failed = 0;
  int bursts = 0;
  int we_cycles = 0;
  int acks = 0;
  int cpu_grants = 0;
  int ready_hi = 0;
  logic prev_ce = 1'b0;
  logic vid_en = 1'b0;
  logic [AW-1:0] cur_vaddr = '0;
  logic [AW-1:0] cur_caddr = '0;
  logic [7:0] vq [$];
  logic [7:0] cq [$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; observe outputs at the falling edge.
  task automatic tick();
    @(negedge clock);
    if (ram_ce && !prev_ce) begin
      bursts++;
      if (vid_en && !ram_we && ram_address == cur_vaddr)
        vq.push_back(mem[cur_vaddr]);
      if (ram_address == cur_caddr) cpu_grants++;
    end
    if (ram_we) we_cycles++;
    if (video_ack) begin
      acks++;
      if (vq.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL video_ack: got unexpected pulse, required none");
      end else begin
        chk("video_data", {24'h0, video_data_out}, {24'h0, vq.pop_front()});
      end
    end
    if (cpu_req && cpu_ready) ready_hi++;
    prev_ce = ram_ce;
  endtask

  task automatic run_cpu(input vec_t v);
    int b0;
    int w0;
    logic [7:0] e;
    b0 = bursts;
    w0 = we_cycles;
    cur_caddr   = v.addr;
    cpu_req     = 1'b1;
    cpu_we      = v.we;
    cpu_address = v.addr;
    cpu_data_in = v.wdata;
    if (!v.we) cq.push_back(v.rdata);
    for (int k = 0; k < LAT; k++) begin
      tick();
      chk("ready_low", cpu_ready, 0);
      chk("ce_on", ram_ce, 1);
      chk("ram_addr", ram_address, v.addr);
      chk("ram_we", ram_we, v.we);
      if (v.we) chk("ram_wdata", ram_data_out, v.wdata);
    end
    tick();
    chk("ready_high", cpu_ready, 1);
    chk("ce_off", ram_ce, 0);
    if (!v.we) begin
      e = cq.pop_front();
      chk("cpu_data", cpu_data_out, e);
    end
    repeat (2) tick();
    chk("hold_ready", cpu_ready, 1);
    chk("one_burst", bursts - b0, 1);
    chk("we_cycles", we_cycles - w0, v.we ? LAT : 0);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    tick();
    chk("ready_idle", cpu_ready, 1);
  endtask

  initial begin
    int a0;
    int g0;
    int r0;
    logic [7:0] e;

    vecs[0] = '{1'b0, 17'h00100, 8'h00, 8'hA5};
    vecs[1] = '{1'b1, 17'h1FFFF, 8'h3C, 8'h00};
    vecs[2] = '{1'b0, 17'h1FFFF, 8'h00, 8'h3C};
    vecs[3] = '{1'b1, 17'h00000, 8'h5A, 8'h00};
    vecs[4] = '{1'b0, 17'h00000, 8'h00, 8'h5A};
    vecs[5] = '{1'b0, 17'h00100, 8'h00, 8'hA5};

    // Reset values and combinational ready during reset.
    repeat (3) tick();
    chk("rst_ce", ram_ce, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_wdata", ram_data_out, 0);
    chk("rst_cpu_data", cpu_data_out, 0);
    chk("rst_vid_data", video_data_out, 0);
    chk("rst_ack", video_ack, 0);
    chk("rst_ready", cpu_ready, 1);
    cpu_req = 1'b1;
    #1 chk("rst_ready_req", cpu_ready, 0);
    cpu_req = 1'b0;
    #1 reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_cpu(vecs[i]);

    // Video request dropped after grant still completes.
    a0 = acks;
    r0 = we_cycles;
    vid_en = 1'b1;
    cur_vaddr = 17'h00200;
    video_address = 17'h00200;
    video_req = 1'b1;
    tick();
    video_req = 1'b0;
    repeat (5) tick();
    chk("vid_one_ack", acks - a0, 1);
    chk("vid_no_we", we_cycles - r0, 0);
    chk("vid_q_empty", vq.size(), 0);
    vid_en = 1'b0;

    // CPU write dropped in its first access cycle.
    cur_caddr   = 17'h00042;
    cpu_req     = 1'b1;
    cpu_we      = 1'b1;
    cpu_address = 17'h00042;
    cpu_data_in = 8'hC3;
    tick();
    cpu_req = 1'b0;
    chk("drop_ce0", ram_ce, 1);
    tick();
    chk("drop_ce1", ram_ce, 1);
    chk("drop_we1", ram_we, 1);
    tick();
    chk("drop_ce_off", ram_ce, 0);
    run_cpu('{1'b0, 17'h00042, 8'h00, 8'hC3});

    // Continuous video plus a waiting CPU read.
    a0 = acks;
    vid_en = 1'b1;
    cur_vaddr = 17'h00200;
    cur_caddr = 17'h00100;
    g0 = cpu_grants;
    r0 = ready_hi;
    video_address = 17'h00200;
    video_req = 1'b1;
    cpu_address = 17'h00100;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    cq.push_back(8'hA5);
`ifdef MEMORY_ARBITER_FAIR_EN
    for (int i = 0; i < 40 && cpu_grants == g0; i++) tick();
    chk("fair_cpu_grant", cpu_grants - g0, 1);
    chk("fair_acks", acks - a0, 3);
    chk("fair_ready_low", ready_hi - r0, 0);
`else
    repeat (30) tick();
    chk("nofair_no_grant", cpu_grants - g0, 0);
    chk("nofair_ready_low", ready_hi - r0, 0);
    chk("nofair_acks", (acks - a0) >= 8, 1);
    video_req = 1'b0;
`endif
    for (int i = 0; i < 12 && !cpu_ready; i++) tick();
    chk("cont_ready", cpu_ready, 1);
    e = cq.pop_front();
    chk("cont_cpu_data", cpu_data_out, e);
    video_req = 1'b0;
    cpu_req = 1'b0;
    repeat (6) tick();
    chk("cont_q_empty", vq.size(), 0);

    // Reset in the middle of a video access.
    a0 = acks;
    video_address = 17'h00200;
    video_req = 1'b1;
    tick();
    chk("mid_ce", ram_ce, 1);
    video_req = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk("mid_rst_ce", ram_ce, 0);
    chk("mid_rst_addr", ram_address, 0);
    vq.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("mid_no_ack", acks - a0, 0);
    chk("mid_ce_idle", ram_ce, 0);
    vid_en = 1'b0;
    run_cpu(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
